lsu: RTL and testbench

Load/store unit between the datapath and the word-wide data memory. Accepts one byte/halfword/word load or store per request, sign- or zero-extends load data, and performs sub-word stores as a read-modify-write on the 32-bit word memory. It drives the memory's addr/wdata/we and consumes its registered rdata, which is valid one cycle after a read-address edge.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 168 ++++++++++++++++
 tb/tb_lsu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: data width, request size
// encodings and a misalignment helper.
// The helper only matters when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    // A halfword needs an even address and a word needs a 4-byte-aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = lane[0];
            default:    mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit. It is purely combinational.
// It extracts and extends a byte or halfword lane from a memory word for loads.
// It merges store data into a memory word for sub-word stores.
// Little-endian: lane 0 is bits [7:0].
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [7:0]  byte_field;
    logic [15:0] half_field;
    logic [4:0]  byte_base;
    logic [4:0]  half_base;

    // A halfword lane ignores addr[0], so a misaligned half that is not
    // trapped reads the aligned half that contains it.
    assign byte_base = {lane, 3'b000};
    assign half_base = {lane[1], 4'b0000};

    assign byte_field = rdata[byte_base +: 8];
    assign half_field = rdata[half_base +: 16];

    // Load path: select the field, then sign- or zero-extend it. A word ignores zero_ext.
    always_comb begin
        load_data = rdata;
        case (size)
            MEM_SIZE_B: load_data = {{(XLEN-8){byte_field[7] & ~zero_ext}}, byte_field};
            MEM_SIZE_H: load_data = {{(XLEN-16){half_field[15] & ~zero_ext}}, half_field};
            default:    load_data = rdata;
        endcase
    end

    // Store path: overwrite only the addressed lane and keep the other bytes of the word.
    always_comb begin
        merge_data = rdata;
        case (size)
            MEM_SIZE_B: merge_data[byte_base +: 8]  = wdata[7:0];
            MEM_SIZE_H: merge_data[half_base +: 16] = wdata[15:0];
            default:    merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the datapath and a word-wide synchronous-read data memory.
// Sub-word stores are done as a read-modify-write.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests.
// A rejected request makes no memory access and returns resp_err=1.
// Without the macro, the misaligned low address bits are ignored and the access proceeds.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        EXT   = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t          state;
    logic            we_reg;
    logic [1:0]      size_reg;
    logic            zext_reg;
    logic [1:0]      lane_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] mem_addr_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic [XLEN-1:0] resp_rdata_reg;
    logic            resp_valid_reg;

    logic [1:0]      req_size_norm;
    logic            req_misaligned;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    // Size 11 behaves exactly like a word from the moment it is accepted.
    assign req_size_norm = (req_size == 2'b11) ? MEM_SIZE_W : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
    logic resp_err_reg;
    assign req_misaligned = is_misaligned(req_size_norm, req_addr[1:0]);
    assign resp_err       = resp_err_reg;
`else
    assign req_misaligned = 1'b0;
    assign resp_err       = 1'b0;
`endif

    lsu_align u_align (
        .rdata      (mem_rdata),
        .wdata      (wdata_reg),
        .lane       (lane_reg),
        .size       (size_reg),
        .zero_ext   (zext_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // The write strobe is decoded from state, so a reset kills a pending merge write at once.
    // During MERGE the merged word goes straight to memory, because the read data is only valid in that cycle.
    assign req_ready  = (state == IDLE);
    assign mem_we     = (state == WR) || (state == MERGE);
    assign mem_wdata  = (state == MERGE) ? merge_data : mem_wdata_reg;
    assign mem_addr   = mem_addr_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;

    // Request FSM: sequence the memory access and register all response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= MEM_SIZE_W;
            zext_reg       <= 1'b0;
            lane_reg       <= 2'b00;
            wdata_reg      <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_rdata_reg <= '0;
            resp_valid_reg <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        size_reg  <= req_size_norm;
                        zext_reg  <= req_unsigned;
                        lane_reg  <= req_addr[1:0];
                        wdata_reg <= req_wdata;
                        if (req_misaligned) begin
                            // A trapped request skips memory entirely and responds in the next cycle.
                            state          <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                            resp_err_reg   <= 1'b1;
`endif
                        end else begin
                            mem_addr_reg <= {req_addr[XLEN-1:2], 2'b00};
                            if (req_we && (req_size_norm == MEM_SIZE_W)) begin
                                mem_wdata_reg <= req_wdata;
                                state         <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    state <= we_reg ? MERGE : EXT;
                end
                EXT: begin
                    state          <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= load_data;
`ifdef LSU_MISALIGN_TRAP_EN
                    resp_err_reg   <= 1'b0;
`endif
                end
                MERGE: begin
                    // Keep the written word on mem_wdata after the access finishes.
                    mem_wdata_reg  <= merge_data;
                    state          <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    resp_err_reg   <= 1'b0;
`endif
                end
                WR: begin
                    state          <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    resp_err_reg   <= 1'b0;
`endif
                end
                RESP: begin
                    state          <= IDLE;
                    resp_valid_reg <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu. It contains a word memory model with registered read data.
// A scoreboard queue holds the expected responses, and a negedge monitor compares them.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int writes = 0;
    int resp_seen = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        preload = 1'b1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [0:63];

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, write on the edge that ends a mem_we cycle.
    always @(posedge clk) begin
        if (preload)
            mem[4] <= 32'h8899AABB;
        else if (mem_we)
            mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: count writes and compare every response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            writes++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (rst_n && resp_valid) begin
            exp_t e;
            resp_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.due);
            end
        end
    end

    task automatic xact(input string tag, input logic we, input logic [1:0] size,
                        input logic zx, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input int exp_writes);
        int w0;
        int s0;
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = zx;
        req_addr = addr;
        req_wdata = wdata;
        w0 = writes;
        s0 = resp_seen;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.due = cyc + lat;
        exp_q.push_back(e);
        for (int i = 0; i < 10 && resp_seen == s0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_resp_count"}, resp_seen - s0, 32'd1);
        check({tag, "_writes"}, writes - w0, exp_writes);
        $display("[TB] %s we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b",
                 tag, we, size, addr, wdata, resp_rdata, resp_err);
    endtask

    initial begin
        int s0;
        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;

        xact("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
        xact("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 0);
        xact("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        xact("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 0);
        xact("lw_10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
        xact("lb_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        xact("lh_11_trap", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        xact("lh_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
`endif
        xact("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 2, 1);
        check("sb_11_waddr", last_waddr, 32'h10);
        check("sb_11_wdata", last_wdata, 32'h889955BB);
        xact("lw_10_rb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 0);
        xact("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 1, 1);
        check("sw_20_waddr", last_waddr, 32'h20);
        check("sw_20_wdata", last_wdata, 32'h12345678);
        xact("lw11_20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 2, 0);
        xact("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 2, 1);
        check("sh_22_wdata", last_wdata, 32'hCAFE5678);
        xact("lw_20_rb", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE5678, 1'b0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        xact("lw_21_trap", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0);
        check("trap_no_addr_change", mem_addr, 32'h20);
`else
        xact("lw_21", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'hCAFE5678, 1'b0, 2, 0);
`endif

        // Reset during MERGE: the write strobe must drop immediately and nothing may respond.
        @(negedge clk);
        s0 = resp_seen;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h20;
        req_wdata = 32'h000000EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("merge_we_high", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("merge_rst_we", {31'd0, mem_we}, 32'd0);
        check("merge_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("merge_rst_ready", {31'd0, req_ready}, 32'd1);
        check("merge_rst_no_resp", resp_seen - s0, 32'd0);
        check("merge_rst_mem", mem[8], 32'hCAFE5678);
        $display("[TB] reset_in_merge mem[0x20]=%h ready=%0b", mem[8], req_ready);
        xact("lw_20_post", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE5678, 1'b0, 2, 0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
